// File: rtl/ema_mc_sched_if.sv
// ---------------------------------------------------------------------------
// ema_mc_sched_if
// Bundle between the per-channel sample sources / result consumer and the
// shared EMA scheduler.
//   req_i   [N_CH]    per-channel request, held until ack_o
//   x_i     [N_CH*W]  flattened signed samples, channel k at [k*W +: W]
//   alpha_i [16]      unsigned Q0.16 smoothing factor, sampled at grant
//   ack_o   [N_CH]    one-hot, one-cycle capture pulse
//   y_o     [W]       filtered result (signed)
//   ch_o    [CH_W]    channel tag for y_o
//   valid_o           one-cycle pulse qualifying y_o/ch_o
//   busy_o            scheduler is working on a sample
// master = requester/consumer side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface ema_mc_sched_if #(
    parameter int N_CH = 4,
    parameter int W    = 16
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]       req_i;
    logic [N_CH*W-1:0]     x_i;
    logic [15:0]           alpha_i;
    logic [N_CH-1:0]       ack_o;
    logic signed [W-1:0]   y_o;
    logic [CH_W-1:0]       ch_o;
    logic                  valid_o;
    logic                  busy_o;

    modport master (
        output req_i, x_i, alpha_i,
        input  ack_o, y_o, ch_o, valid_o, busy_o
    );

    modport slave (
        input  req_i, x_i, alpha_i,
        output ack_o, y_o, ch_o, valid_o, busy_o
    );
endinterface

// File: rtl/ema_mc_sched.sv
// ---------------------------------------------------------------------------
// ema_mc_sched
// Shares one EMA datapath (one multiplier) among N_CH requesters.
// Round-robin grant in IDLE, then SUB (d = x - y), MUL (p = d * alpha),
// UPD (y += p >>> 16, or y = x for a channel's first sample).
// Ports:
//   clk   rising-edge system clock
//   rst   synchronous, active-high reset
//   bus   ema_mc_sched_if.slave (requests, samples, alpha, ack, result)
// Grant-to-valid latency is 3 cycles; one sample every 4 cycles overall.
// ---------------------------------------------------------------------------
module ema_mc_sched #(
    parameter int N_CH = 4,
    parameter int W    = 16
) (
    input  logic           clk,
    input  logic           rst,
    ema_mc_sched_if.slave  bus
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PW   = W + 18;   // (W+1)-bit d times 17-bit {0,alpha}

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SUB  = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_UPD  = 2'd3;

    logic [1:0]            state;
    logic [CH_W-1:0]       ptr;
    logic [CH_W-1:0]       ch_r;
    logic signed [W-1:0]   x_r;
    logic [15:0]           alpha_r;
    logic signed [W:0]     d_r;
    logic signed [PW-1:0]  p_r;
    logic signed [W-1:0]   y_mem [N_CH];
    logic [N_CH-1:0]       primed;

    // ---------------- round-robin arbiter ----------------
    logic                  grant_found;
    logic [CH_W-1:0]       grant_ch;
    logic [CH_W-1:0]       idx;
    logic signed [W-1:0]   x_sel;

    // NOTE: every variable written here gets a default first, otherwise a
    // path that skips the assignment would infer a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = ptr;
        idx         = '0;
        // Search starts one past the last grant and wraps, so the most
        // recently served channel has the lowest priority.
        for (int i = 1; i <= N_CH; i++) begin
            idx = CH_W'((int'(ptr) + i) % N_CH);
            if (!grant_found && bus.req_i[idx]) begin
                grant_found = 1'b1;
                grant_ch    = idx;
            end
        end
    end

    always_comb begin
        x_sel = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant_ch == CH_W'(k)) begin
                x_sel = bus.x_i[k*W +: W];
            end
        end
    end

    // ---------------- datapath ----------------
    logic signed [W-1:0]   y_cur;
    logic signed [W:0]     d_next;
    logic signed [PW-1:0]  p_next;
    logic signed [W-1:0]   y_new;
    logic                  p_unused;

    assign y_cur  = y_mem[ch_r];
    assign d_next = $signed({x_r[W-1], x_r}) - $signed({y_cur[W-1], y_cur});
    assign p_next = $signed({{17{d_r[W]}}, d_r}) * $signed({{(W+2){1'b0}}, alpha_r});

    // Taking bits [W+15:16] is p >>> 16 truncated to W bits. Since alpha < 1
    // the updated value lies between old y and x, so the wrap-around add is
    // exact and needs no saturation.
    assign y_new  = primed[ch_r] ? (y_cur + p_r[W+15:16]) : x_r;

    // Fraction bits and guard bits of the product are intentionally dropped.
    assign p_unused = ^{p_r[15:0], p_r[PW-1:W+16]};

    assign bus.busy_o = (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= CH_W'(N_CH - 1);
            ch_r        <= '0;
            x_r         <= '0;
            alpha_r     <= '0;
            d_r         <= '0;
            p_r         <= '0;
            primed      <= '0;
            // NOTE: the filter state bank is small and architecturally
            // visible (reset to 0), so it is cleared here rather than left
            // as an unreset RAM.
            for (int k = 0; k < N_CH; k++) begin
                y_mem[k] <= '0;
            end
            bus.ack_o   <= '0;
            bus.valid_o <= 1'b0;
            bus.y_o     <= '0;
            bus.ch_o    <= '0;
        end else begin
            bus.ack_o   <= '0;
            bus.valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        ch_r                <= grant_ch;
                        ptr                 <= grant_ch;
                        x_r                 <= x_sel;
                        alpha_r             <= bus.alpha_i;
                        bus.ack_o[grant_ch] <= 1'b1;
                        state               <= S_SUB;
                    end
                end
                S_SUB: begin
                    d_r   <= d_next;
                    state <= S_MUL;
                end
                S_MUL: begin
                    p_r   <= p_next;
                    state <= S_UPD;
                end
                S_UPD: begin
                    y_mem[ch_r]  <= y_new;
                    primed[ch_r] <= 1'b1;
                    bus.y_o      <= y_new;
                    bus.ch_o     <= ch_r;
                    bus.valid_o  <= 1'b1;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ema_mc_sched.sv
// ---------------------------------------------------------------------------
// tb_ema_mc_sched
// Scoreboard bench: expected (channel, result) pairs are queued when a grant
// is observed and compared by a monitor whenever valid_o pulses.
// ---------------------------------------------------------------------------
module tb_ema_mc_sched;
    localparam int N_CH = 4;
    localparam int W    = 16;
    localparam logic [15:0] A04 = 16'd26214;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ema_mc_sched_if #(.N_CH(N_CH), .W(W)) bus ();
    ema_mc_sched #(.N_CH(N_CH), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int                  ch;
        logic signed [W-1:0] y;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    longint my[N_CH];
    bit     mp[N_CH];

    always @(posedge clk) cyc++;

    // Result monitor: every valid_o must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.valid_o === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL result: unexpected valid ch=%0d y=%0d", bus.ch_o, bus.y_o);
            end else begin
                e = sb.pop_front();
                if (int'(bus.ch_o) !== e.ch || bus.y_o !== e.y) begin
                    errors++;
                    $display("FAIL result: got ch=%0d y=%0d, expected ch=%0d y=%0d",
                             bus.ch_o, bus.y_o, e.ch, e.y);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Independent 64-bit reference of the EMA update.
    function automatic logic signed [W-1:0] model(input int ch, input logic signed [W-1:0] x,
                                                   input logic [15:0] a);
        longint d, p, y;
        if (!mp[ch]) begin
            y = longint'(x);
        end else begin
            d = longint'(x) - my[ch];
            p = d * longint'(a);
            y = my[ch] + (p >>> 16);
        end
        my[ch] = y;
        mp[ch] = 1'b1;
        return W'(y);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N_CH; k++) begin
            my[k] = 0;
            mp[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        bus.req_i  = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // Waits for any ack (bounded), then checks it is the expected one-hot.
    task automatic wait_ack(input int ch, output bit ok);
        logic [N_CH-1:0] exp_ack;
        exp_ack     = '0;
        exp_ack[ch] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.ack_o !== '0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ack_timeout: no ack, expected ch=%0d", ch);
        end else if (bus.ack_o !== exp_ack) begin
            errors++;
            $display("FAIL ack: got %b, expected %b", bus.ack_o, exp_ack);
        end
    endtask

    // Presents one sample, queues its expected result and checks latency.
    task automatic send(input int ch, input logic signed [W-1:0] x,
                        input logic [15:0] a, input logic signed [W-1:0] exp_y);
        bit ok;
        int lat;
        exp_t e;
        @(negedge clk);
        bus.req_i[ch]          = 1'b1;
        bus.x_i[ch*W +: W]     = x;
        bus.alpha_i            = a;
        wait_ack(ch, ok);
        bus.req_i[ch] = 1'b0;
        if (ok) begin
            e.ch = ch;
            e.y  = exp_y;
            sb.push_back(e);
            lat = 0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                lat++;
                if (bus.valid_o === 1'b1) break;
            end
            checks++;
            if (lat !== 3) begin
                errors++;
                $display("FAIL latency: got %0d cycles, expected 3", lat);
            end
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.req_i   = N_CH'($urandom);
        bus.x_i     = {$urandom, $urandom};
        bus.alpha_i = A04;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            checks++;
            if ({bus.ack_o, bus.valid_o, bus.busy_o, bus.y_o, bus.ch_o} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: ack=%b valid=%b busy=%b y=%0d ch=%0d, expected all 0",
                         bus.ack_o, bus.valid_o, bus.busy_o, bus.y_o, bus.ch_o);
            end
            bus.req_i = N_CH'($urandom);
        end
        bus.req_i = '0;
        rst       = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++;
            if (bus.busy_o !== 1'b0) begin
                errors++;
                $display("FAIL idle_busy: got %b, expected 0", bus.busy_o);
            end
        end
    endtask

    task automatic test_single_step();
        send(0, 16'sd100, A04, 16'sd100);
        send(0, 16'sd200, A04, 16'sd139);
    endtask

    task automatic test_negative_floor();
        send(1, 16'sd0, A04, 16'sd0);
        send(1, -16'sd100, A04, -16'sd40);
    endtask

    task automatic test_extremes();
        send(3, -16'sd32768, 16'hFFFF, -16'sd32768);
        send(3, 16'sd32767, 16'hFFFF, 16'sd32766);
    endtask

    task automatic test_round_robin();
        logic signed [W-1:0] xs[N_CH];
        int order[4];
        int last;
        bit ok;
        exp_t e;
        do_reset();
        order = '{0, 2, 0, 2};
        last  = 0;
        for (int k = 0; k < N_CH; k++) begin
            xs[k] = W'($urandom_range(0, 2000)) - 16'sd1000;
            bus.x_i[k*W +: W] = xs[k];
        end
        bus.alpha_i = A04;
        bus.req_i   = '1;
        for (int k = 0; k < 12; k++) begin
            int c;
            c = (k < 8) ? (k % N_CH) : order[k-8];
            wait_ack(c, ok);
            if (!ok) break;
            if (k > 0) begin
                checks++;
                if (cyc - last !== 4) begin
                    errors++;
                    $display("FAIL rr_spacing: got %0d cycles between grants, expected 4", cyc - last);
                end
            end
            last = cyc;
            e.ch = c;
            e.y  = model(c, xs[c], A04);
            sb.push_back(e);
            // Next sample for this channel is presented before it can be regranted.
            xs[c] = W'($urandom_range(0, 2000)) - 16'sd1000;
            bus.x_i[c*W +: W] = xs[c];
            if (k == 7) bus.req_i = 4'b0101;
        end
        bus.req_i = '0;
    endtask

    task automatic test_reset_midop();
        bit ok;
        do_reset();
        send(2, 16'sd80, A04, 16'sd80);
        @(negedge clk);
        bus.req_i[2]       = 1'b1;
        bus.x_i[2*W +: W]  = 16'sd120;
        wait_ack(2, ok);
        bus.req_i[2] = 1'b0;
        @(negedge clk);          // FSM now in MUL
        rst = 1'b1;
        @(negedge clk);          // reset sampled during MUL
        checks++;
        if (bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: busy=%b valid=%b, expected 0 0", bus.busy_o, bus.valid_o);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send(2, 16'sd50, A04, 16'sd50);
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    initial begin
        bus.req_i   = '0;
        bus.x_i     = '0;
        bus.alpha_i = '0;
        rst         = 1'b1;
        model_clear();
        test_reset();
        test_single_step();
        test_negative_floor();
        test_extremes();
        test_round_robin();
        drain();
        test_reset_midop();
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
